score_display_seq: RTL and testbench

- Parametrised, sequential successor to the four-digit score display path.
- Converts a WIDTH-bit unsigned score into DIGITS decimal digits with an iterative shift-add-3 (double-dabble) engine, one bit per cycle.
- Holds the committed digits in registers and drives DIGITS seven-segment displays.
- Sits between the game score counter and the board displays; a Load/Busy/Done handshake replaces purely combinational divide-by-10.

---
 rtl/score_display_pkg.sv | 30 +++
 rtl/seg7_encode.sv | 31 +++
 rtl/score_display_seq.sv | 106 ++++++++++
 tb/tb_score_display_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/score_display_pkg.sv
// Shared types and constants for the sequential score display.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package score_display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      COMMIT  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

// File: rtl/seg7_encode.sv
// One decimal digit to active-low seven-segment pattern; combinational.
// Disabled or blanked digits drive all segments off.
module seg7_encode
   import score_display_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       en,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (en && !blank) begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/score_display_seq.sv
// Sequential double-dabble score display: Load->Done in WIDTH+2 cycles, Load ignored while Busy.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits above the ones digit.
module score_display_seq
   import score_display_pkg::*;
#(
   parameter int WIDTH  = 13,
   parameter int DIGITS = 4
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic [WIDTH-1:0]      X,
   input  logic                  Load,
   input  logic                  Display,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Overflow,
   output logic [7*DIGITS-1:0]   Screens
);

   localparam int          BW      = 4 * DIGITS;
   localparam int          CW      = $clog2(WIDTH + 1);
   localparam logic [63:0] OVF_LIM = pow10(DIGITS);

   state_t            state;
   logic [WIDTH-1:0]  sh;
   logic [BW-1:0]     bcd;
   logic [BW-1:0]     bcd_adj;
   logic [BW-1:0]     digits;
   logic [CW-1:0]     cnt;
   logic              ovf_pending;
   logic [DIGITS-1:0] blank;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state       <= IDLE;
         Done        <= 1'b0;
         Overflow    <= 1'b0;
         digits      <= '0;
         sh          <= '0;
         bcd         <= '0;
         cnt         <= '0;
         ovf_pending <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (Load) begin
                  sh          <= X;
                  bcd         <= '0;
                  cnt         <= '0;
                  ovf_pending <= ({{(64-WIDTH){1'b0}}, X} >= OVF_LIM);
                  state       <= CONVERT;
               end
            end
            CONVERT: begin
               // Bits shifted out of the top nibble only matter when the
               // value overflows, and that case saturates at commit.
               {bcd, sh} <= {bcd_adj, sh} << 1;
               cnt       <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) state <= COMMIT;
            end
            COMMIT: begin
               digits   <= ovf_pending ? {DIGITS{4'h9}} : bcd;
               Overflow <= ovf_pending;
               Done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign Busy = (state != IDLE);

`ifdef LEADING_ZERO_BLANK_EN
   logic lz_run;

   always_comb begin
      blank  = '0;
      lz_run = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         lz_run   = lz_run && (digits[4*i +: 4] == 4'd0);
         blank[i] = lz_run;
      end
   end
`else
   assign blank = '0;
`endif

   for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      seg7_encode u_seg (
         .digit (digits[4*g +: 4]),
         .en    (Display),
         .blank (blank[g]),
         .seg   (Screens[7*g +: 7])
      );
   end

endmodule

// File: tb/tb_score_display_seq.sv
// Directed bench for score_display_seq: default, wide (20/6) and overflow-capable (14/4) instances.
module tb_score_display_seq;

   logic        Clock;
   logic        Reset;
   logic        Display;

   logic [12:0] x1;
   logic        load1, busy1, done1, ovf1;
   logic [27:0] scr1;
   logic [19:0] x2;
   logic        load2, busy2, done2, ovf2;
   logic [41:0] scr2;
   logic [13:0] x3;
   logic        load3, busy3, done3, ovf3;
   logic [27:0] scr3;

   int total = 0;
   int bad   = 0;

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [27:0] E_ZERO  = {7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [41:0] E_ZERO6 = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
   localparam logic [27:0] E_42    = {7'h7F, 7'h7F, 7'h19, 7'h24};
   localparam logic [27:0] E_7     = {7'h7F, 7'h7F, 7'h7F, 7'h78};
   localparam logic [27:0] E_555   = {7'h7F, 7'h12, 7'h12, 7'h12};
`else
   localparam logic [27:0] E_ZERO  = {7'h40, 7'h40, 7'h40, 7'h40};
   localparam logic [41:0] E_ZERO6 = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
   localparam logic [27:0] E_42    = {7'h40, 7'h40, 7'h19, 7'h24};
   localparam logic [27:0] E_7     = {7'h40, 7'h40, 7'h40, 7'h78};
   localparam logic [27:0] E_555   = {7'h40, 7'h12, 7'h12, 7'h12};
`endif
   localparam logic [27:0] E_1234  = {7'h79, 7'h24, 7'h30, 7'h19};
   localparam logic [27:0] E_9S    = {7'h10, 7'h10, 7'h10, 7'h10};
   localparam logic [41:0] E_9S6   = {7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10};
   localparam logic [27:0] E_OFF4  = 28'hFFF_FFFF;
   localparam logic [41:0] E_OFF6  = 42'h3FF_FFFF_FFFF;

   score_display_seq #(.WIDTH(13), .DIGITS(4)) dut1 (
      .Clock(Clock), .Reset(Reset), .X(x1), .Load(load1), .Display(Display),
      .Busy(busy1), .Done(done1), .Overflow(ovf1), .Screens(scr1));

   score_display_seq #(.WIDTH(20), .DIGITS(6)) dut2 (
      .Clock(Clock), .Reset(Reset), .X(x2), .Load(load2), .Display(Display),
      .Busy(busy2), .Done(done2), .Overflow(ovf2), .Screens(scr2));

   score_display_seq #(.WIDTH(14), .DIGITS(4)) dut3 (
      .Clock(Clock), .Reset(Reset), .X(x3), .Load(load3), .Display(Display),
      .Busy(busy3), .Done(done3), .Overflow(ovf3), .Screens(scr3));

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Edges counted include the one that samples Load; -1 means Done never came.
   task automatic run_conv(input int which, input logic [19:0] x,
                           output int edges, output logic busy_first);
      logic seen;
      logic d;
      @(negedge Clock);
      case (which)
         1:       begin x1 = x[12:0]; load1 = 1'b1; end
         2:       begin x2 = x;       load2 = 1'b1; end
         default: begin x3 = x[13:0]; load3 = 1'b1; end
      endcase
      edges = 0; seen = 1'b0; busy_first = 1'b0;
      while (!seen && edges < 200) begin
         @(posedge Clock); #1;
         edges++;
         load1 = 1'b0; load2 = 1'b0; load3 = 1'b0;
         d = (which == 1) ? done1 : (which == 2) ? done2 : done3;
         if (edges == 1) busy_first = (which == 1) ? busy1 : (which == 2) ? busy2 : busy3;
         if (d) seen = 1'b1;
      end
      if (!seen) edges = -1;
   endtask

   task automatic test_reset();
      Reset = 1'b1; Display = 1'b1;
      load1 = 1'b0; load2 = 1'b0; load3 = 1'b0;
      x1 = '0; x2 = '0; x3 = '0;
      repeat (3) @(posedge Clock);
      #1 Reset = 1'b0;
      total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
      total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done1); end
      total++; if (ovf3 !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", ovf3); end
      total++; if (scr1 !== E_ZERO) begin bad++; $display("FAIL reset_screens: got %h want %h", scr1, E_ZERO); end
      total++; if (scr2 !== E_ZERO6) begin bad++; $display("FAIL reset_screens6: got %h want %h", scr2, E_ZERO6); end
   endtask

   task automatic test_convert_1234();
      int e; logic b;
      run_conv(1, 20'd1234, e, b);
      total++; if (e !== 15) begin bad++; $display("FAIL lat_1234: got %0d want 15", e); end
      total++; if (b !== 1'b1) begin bad++; $display("FAIL busy_1234: got %b want 1", b); end
      total++; if (scr1 !== E_1234) begin bad++; $display("FAIL scr_1234: got %h want %h", scr1, E_1234); end
      total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL ovf_1234: got %b want 0", ovf1); end
      @(posedge Clock); #1;
      total++; if (done1 !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", done1); end
   endtask

   task automatic test_back_to_back();
      int e; logic b; logic seen; logic b2;
      run_conv(3, 20'd9999, e, b);
      total++; if (e !== 16) begin bad++; $display("FAIL lat_9999: got %0d want 16", e); end
      total++; if (scr3 !== E_9S) begin bad++; $display("FAIL scr_9999: got %h want %h", scr3, E_9S); end
      total++; if (ovf3 !== 1'b0) begin bad++; $display("FAIL ovf_9999: got %b want 0", ovf3); end
      // Still inside the Done cycle: this Load must be accepted.
      x3 = 14'd10000; load3 = 1'b1;
      e = 0; seen = 1'b0; b2 = 1'b0;
      while (!seen && e < 200) begin
         @(posedge Clock); #1;
         e++; load3 = 1'b0;
         if (e == 1) b2 = busy3;
         if (done3) seen = 1'b1;
      end
      total++; if (b2 !== 1'b1) begin bad++; $display("FAIL b2b_accept: got %b want 1", b2); end
      total++; if (e !== 16) begin bad++; $display("FAIL lat_10000: got %0d want 16", e); end
      total++; if (scr3 !== E_9S) begin bad++; $display("FAIL scr_10000: got %h want %h", scr3, E_9S); end
      total++; if (ovf3 !== 1'b1) begin bad++; $display("FAIL ovf_10000: got %b want 1", ovf3); end
   endtask

   task automatic test_load_while_busy();
      int ndone; int first;
      @(negedge Clock); x1 = 13'd42; load1 = 1'b1;
      ndone = 0; first = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge Clock); #1;
         load1 = 1'b0;
         if (i == 3) begin x1 = 13'd7; load1 = 1'b1; end
         if (done1) begin ndone++; if (first < 0) first = i; end
      end
      total++; if (ndone !== 1) begin bad++; $display("FAIL busy_drop_count: got %0d want 1", ndone); end
      total++; if (first !== 15) begin bad++; $display("FAIL busy_drop_lat: got %0d want 15", first); end
      total++; if (scr1 !== E_42) begin bad++; $display("FAIL scr_42: got %h want %h", scr1, E_42); end
   endtask

   task automatic test_small_values();
      int e; logic b;
      run_conv(1, 20'd7, e, b);
      total++; if (scr1 !== E_7) begin bad++; $display("FAIL scr_7: got %h want %h", scr1, E_7); end
      run_conv(1, 20'd0, e, b);
      total++; if (scr1 !== E_ZERO) begin bad++; $display("FAIL scr_0: got %h want %h", scr1, E_ZERO); end
   endtask

   task automatic test_wide();
      int e; logic b;
      run_conv(2, 20'd999999, e, b);
      total++; if (e !== 22) begin bad++; $display("FAIL lat_wide: got %0d want 22", e); end
      total++; if (scr2 !== E_9S6) begin bad++; $display("FAIL scr_wide: got %h want %h", scr2, E_9S6); end
      total++; if (ovf2 !== 1'b0) begin bad++; $display("FAIL ovf_wide: got %b want 0", ovf2); end
   endtask

   task automatic test_display();
      int e; logic b; int ndone;
      run_conv(1, 20'd1234, e, b);
      @(posedge Clock); #1;
      Display = 1'b0; #1;
      total++; if (scr1 !== E_OFF4) begin bad++; $display("FAIL disp_off: got %h want %h", scr1, E_OFF4); end
      total++; if (scr2 !== E_OFF6) begin bad++; $display("FAIL disp_off6: got %h want %h", scr2, E_OFF6); end
      ndone = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge Clock); #1;
         if (done1) ndone++;
      end
      Display = 1'b1; #1;
      total++; if (scr1 !== E_1234) begin bad++; $display("FAIL disp_on: got %h want %h", scr1, E_1234); end
      total++; if (ndone !== 0) begin bad++; $display("FAIL disp_done: got %0d want 0", ndone); end
   endtask

   task automatic test_reset_mid();
      int e; logic b; int ndone;
      run_conv(1, 20'd555, e, b);
      total++; if (scr1 !== E_555) begin bad++; $display("FAIL scr_555: got %h want %h", scr1, E_555); end
      @(negedge Clock); x1 = 13'd8000; load1 = 1'b1;
      @(posedge Clock); #1 load1 = 1'b0;
      repeat (4) @(posedge Clock);
      #1;
      total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy1); end
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL mid_reset_busy: got %b want 0", busy1); end
      ndone = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge Clock); #1;
         if (done1) ndone++;
      end
      total++; if (ndone !== 0) begin bad++; $display("FAIL mid_reset_done: got %0d want 0", ndone); end
      total++; if (scr1 !== E_ZERO) begin bad++; $display("FAIL mid_reset_scr: got %h want %h", scr1, E_ZERO); end
      total++; if (ovf3 !== 1'b0) begin bad++; $display("FAIL mid_reset_ovf: got %b want 0", ovf3); end
   endtask

   initial begin
      test_reset();
      test_convert_1234();
      test_back_to_back();
      test_load_while_busy();
      test_small_values();
      test_wide();
      test_display();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
